i2c_instr_sequencer: RTL

Fetches 32-bit instruction words (op | dev | reg | data) from the read-only register memory and decodes them. Issues each I2C read or write to the I2C master over a valid/ready command channel, then waits for the response. Read results go to the 7-segment datapath as single-cycle beats. The program runs from address 0. With looping compiled in, it repeats the accelerometer poll section indefinitely.

---
 rtl/i2c_instr_sequencer_pkg.sv | 36 +++
 rtl/i2c_instr_sequencer_timeout_ctr.sv | 30 +++
 rtl/i2c_instr_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_instr_sequencer_pkg.sv
// Shared opcode, fault-code, field-position and state definitions for the I2C instruction
// sequencer.
package seq_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_RD  = 8'h01;
  localparam logic [7:0] OP_WR  = 8'h02;

  localparam logic [3:0] FAULT_NONE    = 4'd0;
  localparam logic [3:0] FAULT_MEM     = 4'd1;
  localparam logic [3:0] FAULT_OP      = 4'd2;
  localparam logic [3:0] FAULT_NACK    = 4'd3;
  localparam logic [3:0] FAULT_TIMEOUT = 4'd4;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DEV_MSB  = 22;
  localparam int unsigned DEV_LSB  = 16;
  localparam int unsigned REG_MSB  = 15;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWait,
    StDecode,
    StIssue,
    StResp,
    StAdvance,
    StDone,
    StFault
  } state_e;

endpackage

// File: rtl/i2c_instr_sequencer_timeout_ctr.sv
// Response timeout counter: clear/load/enable, with expiry flagged at RSP_TIMEOUT-1.
module seq_timeout_ctr #(
  parameter int unsigned RSP_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic [((RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1)-1:0] load_value,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == W'(RSP_TIMEOUT - 1));

endmodule

// File: rtl/i2c_instr_sequencer.sv
// Fetches instruction words, issues I2C reads/writes and forwards read bytes.
// Define SEQ_LOOP_EN to make the program re-enter LOOP_START after its last instruction.
module i2c_instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned PROG_LEN    = 4,
  parameter int unsigned LOOP_START  = 2,
  parameter int unsigned RSP_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  input  logic [3:0]           rom_error,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_rw,
  output logic [6:0]           cmd_dev,
  output logic [7:0]           cmd_reg,
  output logic [7:0]           cmd_wdata,
  input  logic                 rsp_valid,
  input  logic                 rsp_nack,
  input  logic [7:0]           rsp_data,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  output logic [ADDR_BITS-1:0] rd_pc,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [3:0]           fault_code
);

  localparam logic [ADDR_BITS-1:0] LastPc = ADDR_BITS'(PROG_LEN - 1);
  localparam int unsigned TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  state_e state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d, rom_addr_q, rom_addr_d, rd_pc_q, rd_pc_d;
  logic       rw_q, rw_d, rd_valid_q, rd_valid_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [3:0] fault_code_q, fault_code_d;
  logic       tmo_clear, tmo_en, tmo_expired;
  logic [7:0] op;

  assign op = rom_data[OP_MSB:OP_LSB];

  // Bit 23 of the device field is reserved and deliberately ignored.
  logic unused_dev_msb;
  assign unused_dev_msb = rom_data[23];

`ifndef SEQ_LOOP_EN
  localparam int unsigned unused_loop_start = LOOP_START;
`endif

  seq_timeout_ctr #(
    .RSP_TIMEOUT(RSP_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (tmo_clear),
    .load      (1'b0),
    .load_value({TW{1'b0}}),
    .enable    (tmo_en),
    .expired   (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      rom_addr_q   <= '0;
      rw_q         <= 1'b0;
      dev_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_pc_q      <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rom_addr_q   <= rom_addr_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_pc_q      <= rd_pc_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rom_addr_d   = rom_addr_q;
    rw_d         = rw_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_pc_d      = rd_pc_q;
    fault_code_d = fault_code_q;
    tmo_clear    = 1'b0;
    tmo_en       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFault: begin
        if (start) begin
          pc_d         = '0;
          fault_code_d = FAULT_NONE;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        rom_addr_d = pc_q;
        state_d    = StWait;
      end
      StWait: state_d = StDecode;
      StDecode: begin
        dev_d = rom_data[DEV_MSB:DEV_LSB];
        reg_d = rom_data[REG_MSB:REG_LSB];
        if (rom_error != 4'd0) begin
          fault_code_d = FAULT_MEM;
          state_d      = StFault;
        end else begin
          case (op)
            OP_NOP: state_d = StAdvance;
            OP_RD: begin
              rw_d    = 1'b1;
              wdata_d = 8'h00;
              state_d = StIssue;
            end
            OP_WR: begin
              rw_d    = 1'b0;
              wdata_d = rom_data[DATA_MSB:DATA_LSB];
              state_d = StIssue;
            end
            default: begin
              fault_code_d = FAULT_OP;
              state_d      = StFault;
            end
          endcase
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          tmo_clear = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        tmo_en = 1'b1;
        // A response arriving on the expiry cycle still wins.
        if (rsp_valid) begin
          if (rsp_nack) begin
            fault_code_d = FAULT_NACK;
            state_d      = StFault;
          end else begin
            if (rw_q) begin
              rd_valid_d = 1'b1;
              rd_data_d  = rsp_data;
              rd_pc_d    = pc_q;
            end
            state_d = StAdvance;
          end
        end else if (tmo_expired) begin
          fault_code_d = FAULT_TIMEOUT;
          state_d      = StFault;
        end
      end
      StAdvance: begin
        if (pc_q == LastPc) begin
`ifdef SEQ_LOOP_EN
          pc_d    = ADDR_BITS'(LOOP_START);
          state_d = StFetch;
`else
          state_d = StDone;
`endif
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rom_addr   = rom_addr_q;
  assign cmd_valid  = (state_q == StIssue);
  assign cmd_rw     = rw_q;
  assign cmd_dev    = dev_q;
  assign cmd_reg    = reg_q;
  assign cmd_wdata  = wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_pc      = rd_pc_q;
  assign busy       = !(state_q inside {StIdle, StDone, StFault});
  assign done       = (state_q == StDone);
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;

endmodule
